// File: rtl/pmu_bridge_pkg.sv
// Shared types and helpers for the APB-to-PMU register bridge.
package pmu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Timeout counter width; at least one bit even when the timeout is disabled.
    function automatic int unsigned tmo_cnt_w(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/pmu_sync_bit.sv
// Reset-to-0 flop chain bringing a single asynchronous bit into the pclk domain.
module pmu_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic pclk,
    input  logic preset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge pclk) begin
        if (preset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pmu_apb_bridge.sv
// APB3 slave forwarding register accesses to an asynchronous PMU register file
// over a 4-phase req/ack handshake, with timeout and address-range errors.
module pmu_apb_bridge
    import pmu_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              pmu_req,
    output logic              pmu_pwrite,
    output logic [ADDR_W-1:0] pmu_paddr,
    output logic [DATA_W-1:0] pmu_pwdata,
    input  logic              pmu_ack,
    input  logic [DATA_W-1:0] pmu_prdata
);

    localparam int unsigned CNT_W = tmo_cnt_w(TIMEOUT_CYC);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ack_s;
    logic             stalled;
    logic             tmo_hit;
    logic             out_of_range;

    pmu_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .pclk   (pclk),
        .preset (preset),
        .d      (pmu_ack),
        .q      (ack_s)
    );

    assign tmo_hit      = (TIMEOUT_CYC != 0) && (32'(cnt) == TIMEOUT_CYC - 1);
    assign out_of_range = 32'(paddr) >= NUM_REGS;

    // A request held off by a stale ack keeps its claim into the access phase.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            cnt        <= '0;
            stalled    <= 1'b0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            pmu_req    <= 1'b0;
            pmu_pwrite <= 1'b0;
            pmu_paddr  <= '0;
            pmu_pwdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (!psel) begin
                        stalled <= 1'b0;
                    end else if (!penable || stalled) begin
                        if (out_of_range) begin
                            stalled <= 1'b0;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            state   <= DONE;
                        end else if (!ack_s) begin
                            stalled    <= 1'b0;
                            pmu_pwrite <= pwrite;
                            pmu_paddr  <= paddr;
                            pmu_pwdata <= pwdata;
                            pmu_req    <= 1'b1;
                            cnt        <= '0;
                            state      <= REQ;
                        end else begin
                            stalled <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        if (!pmu_pwrite) begin
                            prdata <= pmu_prdata;
                        end
                        pmu_req <= 1'b0;
                        cnt     <= '0;
                        state   <= REL;
                    end else if (tmo_hit) begin
                        pmu_req <= 1'b0;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                        state   <= DONE;
                    end else if (tmo_hit) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (psel && penable) begin
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
